// File: rtl/binary_to_bcd_dabble_if.sv
// Request/result bundle between the counter FSM and the double-dabble converter.
// The master drives the request side; the slave (converter) drives the result side.
interface binary_to_bcd_dabble_if #(
   parameter int INPUT_WIDTH    = 16,
   parameter int DECIMAL_DIGITS = 4
);
   logic [INPUT_WIDTH-1:0]      i_binary;
   logic                        i_start;
   logic [4*DECIMAL_DIGITS-1:0] o_bcd;
   logic                        o_dv;
   logic                        o_busy;
   logic                        o_overflow;

   modport master (
      output i_binary, i_start,
      input  o_bcd, o_dv, o_busy, o_overflow
   );

   modport slave (
      input  i_binary, i_start,
      output o_bcd, o_dv, o_busy, o_overflow
   );
endinterface

// File: rtl/binary_to_bcd_dabble.sv
// Sequential double-dabble binary-to-BCD converter with busy/done handshake.
// Each input bit costs one ADD cycle and one SHIFT cycle; digits beyond the top raise overflow.
module binary_to_bcd_dabble #(
   parameter int INPUT_WIDTH    = 16,
   parameter int DECIMAL_DIGITS = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   binary_to_bcd_dabble_if.slave bus
);
   localparam int BCD_W = 4 * DECIMAL_DIGITS;
   localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT} state_t;

   state_t                 r_state;
   logic [INPUT_WIDTH-1:0] r_bin;
   logic [BCD_W-1:0]       r_scr;
   logic                   r_ovf_sticky;
   logic [CNT_W-1:0]       r_cnt;
   logic [BCD_W-1:0]       r_bcd;
   logic                   r_dv;
   logic                   r_busy;
   logic                   r_ovf;

   logic [BCD_W-1:0]       w_scr_adj;
   logic [BCD_W-1:0]       w_scr_shift;
   logic [INPUT_WIDTH-1:0] w_bin_shift;
   logic                   w_ovf_next;

   // Per-digit +3 correction; digits are independent, no carry crosses a nibble.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int d = 0; d < DECIMAL_DIGITS; d++) begin
         if (v[4*d +: 4] > 4'd4)
            r[4*d +: 4] = v[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign w_scr_adj   = add3_digits(r_scr);
   assign w_scr_shift = {r_scr[BCD_W-2:0], r_bin[INPUT_WIDTH-1]};
   assign w_bin_shift = r_bin << 1;
   assign w_ovf_next  = r_ovf_sticky | r_scr[BCD_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_bin        <= '0;
         r_scr        <= '0;
         r_ovf_sticky <= 1'b0;
         r_cnt        <= '0;
         r_bcd        <= '0;
         r_dv         <= 1'b0;
         r_busy       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_dv <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_bin        <= bus.i_binary;
                  r_scr        <= '0;
                  r_ovf_sticky <= 1'b0;
                  r_cnt        <= CNT_W'(INPUT_WIDTH);
                  r_busy       <= 1'b1;
                  r_state      <= S_ADD;
               end
            end
            S_ADD: begin
               r_scr   <= w_scr_adj;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_scr        <= w_scr_shift;
               r_bin        <= w_bin_shift;
               r_ovf_sticky <= w_ovf_next;
               r_cnt        <= r_cnt - CNT_W'(1);
               // Final bit: publish result on the same edge that performs the last shift.
               if (r_cnt == CNT_W'(1)) begin
                  r_bcd   <= w_scr_shift;
                  r_ovf   <= w_ovf_next;
                  r_dv    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_ADD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_bcd      = r_bcd;
   assign bus.o_dv       = r_dv;
   assign bus.o_busy     = r_busy;
   assign bus.o_overflow = r_ovf;
endmodule

// File: tb/tb_binary_to_bcd_dabble.sv
// Directed bench for binary_to_bcd_dabble: latency, busy window, overflow, ignored
// starts, back-to-back acceptance and asynchronous reset abort.
module tb_binary_to_bcd_dabble;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;
   int   bcnt;
   int   dv_seen;

   binary_to_bcd_dabble_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) bus ();

   binary_to_bcd_dabble #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic start_conv(input logic [15:0] val);
      bus.i_binary = val;
      bus.i_start  = 1'b1;
      @(negedge clk);
      bus.i_start  = 1'b0;
   endtask

   // Counts negedges until o_dv is seen (bounded), and busy samples before it.
   task automatic wait_dv(output int cyc, output int busy_cnt);
      cyc = 0;
      busy_cnt = 0;
      while (bus.o_dv !== 1'b1 && cyc < 100) begin
         if (bus.o_busy === 1'b1) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_conv(input string tag, input logic [15:0] val,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
      int c;
      int b;
      start_conv(val);
      wait_dv(c, b);
      check({tag, "_latency"}, c, 32);
      check({tag, "_busy_cycles"}, b, 32);
      check({tag, "_busy_at_dv"}, {31'd0, bus.o_busy}, 0);
      check({tag, "_bcd"}, {16'd0, bus.o_bcd}, {16'd0, exp_bcd});
      check({tag, "_ovf"}, {31'd0, bus.o_overflow}, {31'd0, exp_ovf});
      @(negedge clk);
      check({tag, "_dv_width"}, {31'd0, bus.o_dv}, 0);
      check({tag, "_bcd_hold"}, {16'd0, bus.o_bcd}, {16'd0, exp_bcd});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.i_binary = '0;
      bus.i_start  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd",  {16'd0, bus.o_bcd}, 0);
      check("rst_dv",   {31'd0, bus.o_dv}, 0);
      check("rst_busy", {31'd0, bus.o_busy}, 0);
      check("rst_ovf",  {31'd0, bus.o_overflow}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", {31'd0, bus.o_busy}, 0);

      run_conv("zero",  16'd0,     16'h0000, 1'b0);
      run_conv("v1234", 16'd1234,  16'h1234, 1'b0);
      run_conv("v9999", 16'd9999,  16'h9999, 1'b0);
      run_conv("v10000", 16'd10000, 16'h0000, 1'b1);
      run_conv("v65535", 16'd65535, 16'h5535, 1'b1);
      run_conv("v42",   16'd42,    16'h0042, 1'b0);

      // Start while busy must be ignored.
      start_conv(16'd500);
      repeat (10) @(negedge clk);
      bus.i_binary = 16'd777;
      bus.i_start  = 1'b1;
      @(negedge clk);
      bus.i_start  = 1'b0;
      bus.i_binary = 16'd1111;
      wait_dv(n, bcnt);
      check("busy_ign_latency", 11 + n, 32);
      check("busy_ign_bcd", {16'd0, bus.o_bcd}, 32'h0500);
      dv_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_dv === 1'b1) dv_seen++;
      end
      check("busy_ign_no_second_dv", dv_seen, 0);
      check("busy_ign_idle", {31'd0, bus.o_busy}, 0);

      // Start accepted during the o_dv cycle.
      start_conv(16'd123);
      wait_dv(n, bcnt);
      check("b2b_first_latency", n, 32);
      check("b2b_first_bcd", {16'd0, bus.o_bcd}, 32'h0123);
      start_conv(16'd321);
      check("b2b_second_busy", {31'd0, bus.o_busy}, 1);
      wait_dv(n, bcnt);
      check("b2b_second_latency", n, 32);
      check("b2b_second_bcd", {16'd0, bus.o_bcd}, 32'h0321);
      @(negedge clk);

      // Asynchronous reset mid-conversion.
      start_conv(16'd4321);
      repeat (14) @(negedge clk);
      check("abort_busy_before", {31'd0, bus.o_busy}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_bcd",  {16'd0, bus.o_bcd}, 0);
      check("abort_busy", {31'd0, bus.o_busy}, 0);
      check("abort_dv",   {31'd0, bus.o_dv}, 0);
      check("abort_ovf",  {31'd0, bus.o_overflow}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dv_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_dv === 1'b1) dv_seen++;
      end
      check("abort_no_dv", dv_seen, 0);
      run_conv("v8", 16'd8, 16'h0008, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
